input_scanner: RTL and testbench
================================

INPUT_SCANNER -- requirements
Module: input_scanner

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of each input channel and of q.
REQ-002 Parameter CHANNELS, default 8, SHALL set the number of input channels; it SHALL be a power of two and at least 2.
REQ-003 Parameter SEL_W, default 3, SHALL equal log2(CHANNELS) and set the width of s and q_ch.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-006 Port d_in, input, CHANNELS*WIDTH, SHALL carry the flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port s, input, SEL_W, SHALL give the channel index in direct mode and the start channel in scan mode.
REQ-008 Port mode, input, 2, SHALL select the operating mode: 00 direct, 01 scan, 10 hold, 11 hold.
REQ-009 Port dwell, input, 4, SHALL give the number of extra accepted samples per channel in scan mode (0 means one sample per channel).
REQ-010 Port q_ready, input, 1, SHALL be the consumer ready signal.
REQ-011 Port q, output, WIDTH, SHALL carry the registered sample data.
REQ-012 Port q_ch, output, SEL_W, SHALL carry the channel index q was taken from.
REQ-013 Port q_valid, output, 1, SHALL indicate that q and q_ch hold an unconsumed sample.
REQ-014 Port wrap, output, 1, SHALL pulse for one cycle when the scan pointer moves from CHANNELS-1 to 0.

Function
REQ-015 The output register SHALL be able to load ("load enable") in any cycle where q_valid=0 or q_ready=1.
REQ-016 A sample SHALL be consumed in any cycle where q_valid=1 and q_ready=1.
REQ-017 In direct mode with load enable: q SHALL load channel s, q_ch SHALL load s, and q_valid SHALL be set; latency is 1 clock from s/d_in to q.
REQ-018 Stall (q_valid=1, q_ready=0) in any mode SHALL freeze q, q_ch, q_valid, the scan pointer ptr and the dwell counter cnt.
REQ-019 Scan entry SHALL occur when mode becomes 01 after a cycle where mode was not 01; the first rising edge with mode=01 SHALL load ptr from s and cnt with 0.
REQ-020 On that scan-entry edge, if load is enabled, q SHALL load channel s, q_ch SHALL load s, and q_valid SHALL be set.
REQ-021 In scan mode (not the entry edge) with load enable: q SHALL load channel ptr, q_ch SHALL load ptr, and q_valid SHALL be set.
REQ-022 After such a load in scan mode: if cnt >= dwell, ptr SHALL advance to (ptr+1) mod CHANNELS and cnt SHALL clear; otherwise cnt SHALL increment.
REQ-023 dwell SHALL be compared live each cycle; reducing dwell below cnt SHALL cause an advance on the next accepted load.
REQ-024 wrap SHALL be 1 in the cycle after the edge on which ptr advances from CHANNELS-1 to 0, and 0 in all other cycles.
REQ-025 In hold mode (10 or 11), no load SHALL occur; q and q_ch SHALL hold; q_valid SHALL clear on consumption; ptr and cnt SHALL hold.
REQ-026 Leaving scan mode SHALL retain ptr and cnt, but they SHALL be unused until the next scan entry reloads them.
REQ-027 An inbound load and a consumption in the same cycle SHALL leave q_valid=1 with the new sample, with no bubble.

Reset
REQ-028 While rst_n=0, q=0, q_ch=0, q_valid=0, wrap=0, ptr=0 and cnt=0 SHALL hold, independent of clk.
REQ-029 Reset asserted mid-scan or mid-stall SHALL discard the pending sample.
REQ-030 After reset is released, the first edge with mode=01 SHALL be treated as scan entry.

Verification
REQ-031 Direct mode test: WIDTH=4, CHANNELS=8, channel k = k+3, q_ready=1, s stepped 0..7 -> one cycle later q = s+3, q_ch = s, q_valid=1 each cycle.
REQ-032 Scan mode test: s=6, dwell=1, q_ready=1 -> q_ch sequence 6,6,7,7,0,0,1,1; wrap=1 in exactly the cycle after ptr goes 7->0.
REQ-033 Backpressure test: in scan with dwell=0, hold q_ready=0 for 5 cycles -> q, q_ch and ptr frozen; on release the sequence resumes with no channel skipped or repeated.
REQ-034 Hold mode test: switch to mode=10 with q_valid=1, q_ready=0, then raise q_ready -> q unchanged, q_valid falls after 1 cycle, no further loads.
REQ-035 Reset test: assert rst_n=0 asynchronously between clock edges during scan at ptr=5 -> all outputs 0 immediately; after release, mode=01 with s=2 starts the scan at channel 2.
REQ-036 Dwell change test: with dwell=7 and cnt=4, set dwell=2 -> the pointer advances on the next accepted load.

Source files
------------

// File: rtl/input_scanner.sv
// Multi-channel input scanner: direct select, auto-scan with per-channel
// dwell, or hold, feeding a single registered valid/ready output stage.
module input_scanner #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d_in,
    input  logic [SEL_W-1:0]          s,
    input  logic [1:0]                mode,
    input  logic [3:0]                dwell,
    input  logic                      q_ready,
    output logic [WIDTH-1:0]          q,
    output logic [SEL_W-1:0]          q_ch,
    output logic                      q_valid,
    output logic                      wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [SEL_W-1:0] r_q_ch;
    logic             r_q_valid;
    logic             r_wrap;
    logic [SEL_W-1:0] r_ptr;
    logic [3:0]       r_cnt;
    logic             r_was_scan;

    logic [WIDTH-1:0] w_ch [CHANNELS];
    logic             w_le;
    logic             w_scan;
    logic             w_entry;
    logic             w_load;
    logic             w_adv;
    logic [SEL_W-1:0] w_ptr_eff;
    logic [3:0]       w_cnt_eff;
    logic [SEL_W-1:0] w_sel;
    logic             w_q_valid_n;
    logic [SEL_W-1:0] w_ptr_n;
    logic [3:0]       w_cnt_n;
    logic             w_wrap_n;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign w_ch[k] = d_in[k*WIDTH +: WIDTH];
    end

    // On the entry edge the pointer/counter behave as if already (s, 0),
    // so the entry load counts as the first dwell sample of channel s.
    always_comb begin
        w_le      = !r_q_valid || q_ready;
        w_scan    = (mode == 2'b01);
        w_entry   = w_scan && !r_was_scan;
        w_ptr_eff = w_entry ? s : r_ptr;
        w_cnt_eff = w_entry ? 4'd0 : r_cnt;
        w_sel     = w_scan ? w_ptr_eff : s;
        w_load    = w_le && !mode[1];
        w_adv     = w_scan && w_load && (w_cnt_eff >= dwell);
        w_wrap_n  = w_adv && (w_ptr_eff == LAST);
        if (w_load) begin
            w_q_valid_n = 1'b1;
        end else if (q_ready) begin
            w_q_valid_n = 1'b0;
        end else begin
            w_q_valid_n = r_q_valid;
        end
        w_ptr_n = r_ptr;
        w_cnt_n = r_cnt;
        if (w_adv) begin
            w_ptr_n = w_ptr_eff + ONE;
            w_cnt_n = 4'd0;
        end else if (w_scan && w_load) begin
            w_ptr_n = w_ptr_eff;
            w_cnt_n = w_cnt_eff + 4'd1;
        end else if (w_entry) begin
            w_ptr_n = s;
            w_cnt_n = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_q_ch     <= '0;
            r_q_valid  <= 1'b0;
            r_wrap     <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_was_scan <= 1'b0;
        end else begin
            if (w_load) begin
                r_q    <= w_ch[w_sel];
                r_q_ch <= w_sel;
            end
            r_q_valid  <= w_q_valid_n;
            r_wrap     <= w_wrap_n;
            r_ptr      <= w_ptr_n;
            r_cnt      <= w_cnt_n;
            r_was_scan <= w_scan;
        end
    end

    assign q       = r_q;
    assign q_ch    = r_q_ch;
    assign q_valid = r_q_valid;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_input_scanner.sv
// Bench for input_scanner: directed scenarios plus randomized traffic
// checked against a behavioural model of the scanner's rules.
module tb_input_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_in;
    logic [2:0]  s;
    logic [1:0]  mode;
    logic [3:0]  dwell;
    logic        q_ready;
    logic [3:0]  q;
    logic [2:0]  q_ch;
    logic        q_valid;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int mq, mch, mv, mptr, mcnt, mwrap, mprev;

    always #5 clk = ~clk;

    input_scanner #(.WIDTH(4), .CHANNELS(8), .SEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .s(s),
        .mode(mode), .dwell(dwell), .q_ready(q_ready),
        .q(q), .q_ch(q_ch), .q_valid(q_valid), .wrap(wrap)
    );

    function automatic int chan(int k);
        return int'((d_in >> (k * 4)) & 32'hF);
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq = 0; mch = 0; mv = 0; mptr = 0;
        mcnt = 0; mwrap = 0; mprev = 0;
    endtask

    // Advance model by one edge using current inputs.
    task automatic model_step();
        int p, c, nw;
        bit take;
        take = (mv == 0) || q_ready;
        nw = 0;
        if (mode == 2'b00) begin
            if (take) begin
                mq = chan(s); mch = s; mv = 1;
            end
        end else if (mode == 2'b01) begin
            p = (mprev == 0) ? int'(s) : mptr;
            c = (mprev == 0) ? 0 : mcnt;
            if (take) begin
                mq = chan(p); mch = p; mv = 1;
                if (c >= dwell) begin
                    nw = (p == 7);
                    mptr = (p + 1) % 8;
                    mcnt = 0;
                end else begin
                    mptr = p;
                    mcnt = c + 1;
                end
            end else begin
                mptr = p; mcnt = c;
            end
        end else if (mv == 1 && q_ready) begin
            mv = 0;
        end
        mprev = (mode == 2'b01);
        mwrap = nw;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".q"}, int'(q), mq);
        chk({tag, ".q_ch"}, int'(q_ch), mch);
        chk({tag, ".q_valid"}, int'(q_valid), mv);
        chk({tag, ".wrap"}, int'(wrap), mwrap);
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp32 [8] = '{6, 6, 7, 7, 0, 0, 1, 1};
        int held_ch, held_q, r;
        rst_n = 1'b0;
        d_in = '0; s = '0; mode = 2'b00; dwell = '0; q_ready = 1'b0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // direct mode, channel k = k+3
        for (int k = 0; k < 8; k++) d_in[k*4 +: 4] = 4'(k + 3);
        q_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = 3'(i);
            tick("direct");
            chk("direct.q_lit", int'(q), i + 3);
            chk("direct.ch_lit", int'(q_ch), i);
        end

        // scan from 6 with dwell 1
        mode = 2'b01; s = 3'd6; dwell = 4'd1;
        for (int i = 0; i < 8; i++) begin
            tick("scan");
            chk("scan.ch_seq", int'(q_ch), exp32[i]);
            chk("scan.wrap_seq", int'(wrap), (i == 3) ? 1 : 0);
        end

        // backpressure with dwell 0
        dwell = 4'd0;
        tick("bp_pre");
        tick("bp_pre");
        held_ch = int'(q_ch);
        held_q = int'(q);
        q_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick("bp_stall");
            chk("bp.ch_frozen", int'(q_ch), held_ch);
            chk("bp.q_frozen", int'(q), held_q);
        end
        q_ready = 1'b1;
        tick("bp_rel");
        chk("bp.resume1", int'(q_ch), (held_ch + 1) % 8);
        tick("bp_rel");
        chk("bp.resume2", int'(q_ch), (held_ch + 2) % 8);

        // hold mode
        q_ready = 1'b0;
        tick("hold_pre");
        held_q = int'(q);
        mode = 2'b10;
        tick("hold");
        chk("hold.v_stay", int'(q_valid), 1);
        q_ready = 1'b1;
        tick("hold");
        chk("hold.v_drop", int'(q_valid), 0);
        chk("hold.q_keep", int'(q), held_q);
        mode = 2'b11;
        tick("hold");
        chk("hold.no_load", int'(q_valid), 0);

        // reset mid-scan at ptr 5, restart at channel 2
        mode = 2'b01; s = 3'd3; dwell = 4'd0;
        tick("pre_rst");
        tick("pre_rst");
        do_reset();
        chk("rst.q_zero", int'(q), 0);
        s = 3'd2;
        tick("post_rst");
        chk("rst.restart", int'(q_ch), 2);

        // dwell reduced below count
        mode = 2'b00;
        tick("dw_exit");
        mode = 2'b01; s = 3'd1; dwell = 4'd7;
        for (int i = 0; i < 4; i++) tick("dw_fill");
        chk("dw.still1", int'(q_ch), 1);
        dwell = 4'd2;
        tick("dw_adv");
        chk("dw.last1", int'(q_ch), 1);
        tick("dw_adv");
        chk("dw.next", int'(q_ch), 2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            mode = (r < 2) ? 2'b00 : (r < 8) ? 2'b01 :
                   (r == 8) ? 2'b10 : 2'b11;
            s = 3'($urandom_range(0, 7));
            dwell = 4'($urandom_range(0, 3));
            q_ready = ($urandom_range(0, 3) != 0);
            d_in = $urandom();
            if ($urandom_range(0, 99) == 0) do_reset();
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
